// File: rtl/risc_toy_pkg.sv
// Shared definitions for the RISC_TOY memory-side responders:
// bus widths, DRW encoding, the error read value and a saturating counter helper.
package risc_toy_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;

    localparam logic DRW_WRITE = 1'b1;
    localparam logic DRW_READ  = 1'b0;

    localparam logic [WORD_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Increment an 8-bit count, sticking at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/risc_toy_lat_pipe.sv
// Fixed-depth {valid, data} delay line with synchronous active-low clear.
// Each stage only reloads its data when the upstream stage is valid, so the
// last stage keeps the most recent valid word while nothing new arrives.
module risc_toy_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          w_v_in;
        logic [DW-1:0] w_d_in;
        logic          r_valid;
        logic [DW-1:0] r_data;

        if (g == 0) begin : g_head
            assign w_v_in = i_valid;
            assign w_d_in = i_data;
        end else begin : g_tail
            assign w_v_in = g_stage[g-1].r_valid;
            assign w_d_in = g_stage[g-1].r_data;
        end

        // Advance one stage: valid always shifts, data only moves with a valid word.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= w_v_in;
                if (w_v_in) begin
                    r_data <= w_d_in;
                end else begin
                    r_data <= r_data;
                end
            end
        end
    end

    assign o_valid = g_stage[DEPTH-1].r_valid;
    assign o_data  = g_stage[DEPTH-1].r_data;

endmodule

// File: rtl/risc_toy_dmem_resp.sv
// Data-memory responder for the RISC_TOY data port. Word-addressed RAM, one
// request per cycle, writes commit at the request edge, reads return through
// a fixed-latency pipeline. Out-of-range accesses set a sticky flag and bump
// a saturating counter; out-of-range reads return ERR_DATA.
module risc_toy_dmem_resp
    import risc_toy_pkg::*;
#(
    parameter int                AW       = 10,
    parameter int                RD_LAT   = 1,
    parameter logic [WORD_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              DREQ,
    input  logic              DRW,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [WORD_W-1:0] DWDATA,
    output logic [WORD_W-1:0] DRDATA,
    output logic              RVALID,
    output logic              ERR,
    output logic [7:0]        ERR_CNT
);

    localparam int DEPTH = 1 << AW;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("risc_toy_dmem_resp: RD_LAT must be in 1..4");
    end
    if (AW < 1 || AW > ADDR_W) begin : g_bad_aw
        $error("risc_toy_dmem_resp: AW must be in 1..30");
    end

    logic [WORD_W-1:0] r_mem [DEPTH];

    logic [AW-1:0]     w_idx;
    logic [ADDR_W-1:0] w_hi;
    logic              w_oor;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [WORD_W-1:0] w_rd_data;

    logic              r_err;
    logic [7:0]        r_err_cnt;

    // Decode the request: range check, write/read strobes and the word to launch.
    // Every strobe is qualified by DREQ so idle-cycle bus contents never matter.
    always_comb begin
        w_idx     = DADDR[AW-1:0];
        w_hi      = DADDR >> AW;
        w_oor     = DREQ && (w_hi != 30'd0);
        w_wr_en   = RSTN && DREQ && (DRW == DRW_WRITE) && !w_oor;
        w_rd_en   = DREQ && (DRW == DRW_READ);
        if (w_oor) begin
            w_rd_data = ERR_DATA;
        end else begin
            w_rd_data = r_mem[w_idx];
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= DWDATA;
        end
    end

    // Sticky out-of-range flag and saturating out-of-range counter.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (w_oor) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc8(r_err_cnt);
        end else begin
            r_err     <= r_err;
            r_err_cnt <= r_err_cnt;
        end
    end

    risc_toy_lat_pipe #(
        .DEPTH (RD_LAT),
        .DW    (WORD_W)
    ) u_rd_pipe (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_valid (w_rd_en),
        .i_data  (w_rd_data),
        .o_valid (RVALID),
        .o_data  (DRDATA)
    );

    assign ERR     = r_err;
    assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_risc_toy_dmem_resp.sv
// Bench for risc_toy_dmem_resp: two instances (RD_LAT=1 and RD_LAT=3) share one
// directed stimulus stream. A transaction-level model (RAM array plus a queue
// of reads tagged with their due edge) is checked every cycle, and literal
// expectations pin the key results.
module tb_risc_toy_dmem_resp;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;

    logic [31:0] drdata1, drdata3;
    logic        rvalid1, rvalid3;
    logic        err1, err3;
    logic [7:0]  errcnt1, errcnt3;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 CLK = ~CLK;

    risc_toy_dmem_resp #(.AW(10), .RD_LAT(1)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DRDATA(drdata1), .RVALID(rvalid1), .ERR(err1), .ERR_CNT(errcnt1)
    );

    risc_toy_dmem_resp #(.AW(10), .RD_LAT(3)) dut3 (
        .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DRDATA(drdata3), .RVALID(rvalid3), .ERR(err3), .ERR_CNT(errcnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [31:0] data; } rd_t;
    rd_t         q1[$];
    rd_t         q3[$];
    logic [31:0] m_mem [1024];
    int          cyc = 0;
    logic        m_rv1, m_rv3, m_err;
    logic [31:0] m_rd1, m_rd3;
    int          m_cnt;

    always @(posedge CLK) begin
        bit          oor;
        logic [31:0] d;
        rd_t         e;
        cyc++;
        if (!RSTN) begin
            q1.delete();
            q3.delete();
            m_rv1 = 1'b0; m_rv3 = 1'b0;
            m_rd1 = 32'h0; m_rd3 = 32'h0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            m_rv1 = 1'b0;
            m_rv3 = 1'b0;
            if (DREQ) begin
                oor = (DADDR >= 30'd1024);
                if (DRW) begin
                    if (!oor) m_mem[DADDR[9:0]] = DWDATA;
                end else begin
                    d = oor ? 32'hDEAD_BEEF : m_mem[DADDR[9:0]];
                    q1.push_back('{cyc, d});
                    q3.push_back('{cyc + 2, d});
                end
                if (oor) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                m_rv1 = 1'b1;
                m_rd1 = e.data;
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                e = q3.pop_front();
                m_rv3 = 1'b1;
                m_rd3 = e.data;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_rvalid1", {31'd0, rvalid1}, {31'd0, m_rv1});
            chk("m_drdata1", drdata1, m_rd1);
            chk("m_rvalid3", {31'd0, rvalid3}, {31'd0, m_rv3});
            chk("m_drdata3", drdata3, m_rd3);
            chk("m_err1", {31'd0, err1}, {31'd0, m_err});
            chk("m_err3", {31'd0, err3}, {31'd0, m_err});
            chk("m_errcnt1", {24'd0, errcnt1}, m_cnt);
            chk("m_errcnt3", {24'd0, errcnt3}, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic req, input logic rw, input logic [29:0] a, input logic [31:0] d);
        DREQ = req; DRW = rw; DADDR = a; DWDATA = d;
        step();
    endtask

    logic        rv_log [7];
    logic [31:0] rd_log [7];

    initial begin
        RSTN = 1'b0; DREQ = 1'b0; DRW = 1'b0; DADDR = 30'd0; DWDATA = 32'd0;

        // 1. reset, then idle with junk on the ignored inputs
        step();
        chk_en = 1'b1;
        step();
        RSTN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 30'h3FFF_FFFF, 32'hFFFF_FFFF);
            chk("t1_rvalid", {31'd0, rvalid1}, 32'd0);
            chk("t1_drdata", drdata1, 32'd0);
            chk("t1_errcnt", {24'd0, errcnt1}, 32'd0);
        end
        chk("t1_err", {31'd0, err1}, 32'd0);

        // 2. write then read, RD_LAT=1
        drive(1'b1, 1'b1, 30'd5, 32'h1234_5678);
        chk("t2_no_early_valid", {31'd0, rvalid1}, 32'd0);
        drive(1'b1, 1'b0, 30'd5, 32'd0);
        chk("t2_rvalid", {31'd0, rvalid1}, 32'd1);
        chk("t2_drdata", drdata1, 32'h1234_5678);
        chk("t2_model_pin", m_rd1, 32'h1234_5678);
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        chk("t2_rvalid_drop", {31'd0, rvalid1}, 32'd0);
        chk("t2_drdata_hold", drdata1, 32'h1234_5678);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 30'd0, 32'd0);

        // 3. back-to-back reads, RD_LAT=3
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 30'(i), 32'hA0 + 32'(i));
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 1'b0, 30'(i), 32'd0);
            else       drive(1'b0, 1'b0, 30'd0, 32'd0);
            rv_log[i] = rvalid3;
            rd_log[i] = drdata3;
        end
        chk("t3_no_early0", {31'd0, rv_log[0]}, 32'd0);
        chk("t3_no_early1", {31'd0, rv_log[1]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rvalid", {31'd0, rv_log[i+2]}, 32'd1);
            chk("t3_drdata", rd_log[i+2], 32'hA0 + 32'(i));
        end
        chk("t3_rvalid_end", {31'd0, rv_log[6]}, 32'd0);

        // 4. out of range, AW=10
        drive(1'b1, 1'b1, 30'd0, 32'h0);
        drive(1'b1, 1'b1, 30'h400, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 30'h400, 32'd0);
        chk("t4_oor_rvalid", {31'd0, rvalid1}, 32'd1);
        chk("t4_oor_data", drdata1, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 30'd0, 32'd0);
        chk("t4_addr0_rvalid", {31'd0, rvalid1}, 32'd1);
        chk("t4_addr0_data", drdata1, 32'h0);
        chk("t4_err", {31'd0, err1}, 32'd1);
        chk("t4_errcnt", {24'd0, errcnt1}, 32'd2);
        chk("t4_model_cnt_pin", m_cnt, 32'd2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 30'd0, 32'd0);

        // 5. counter saturation
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 30'h400 + 30'(i), 32'd0);
        chk("t5_errcnt_102", {24'd0, errcnt1}, 32'd102);
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b0, 30'h3FFF_FF00 + 30'(i), 32'd0);
        chk("t5_errcnt_sat", {24'd0, errcnt1}, 32'hFF);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 30'd0, 32'd0);
        chk("t5_errcnt_stays", {24'd0, errcnt3}, 32'hFF);
        chk("t5_err", {31'd0, err3}, 32'd1);

        // 6. reset mid-read, RD_LAT=3
        drive(1'b1, 1'b1, 30'd1, 32'h55);
        drive(1'b1, 1'b0, 30'd1, 32'd0);
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        RSTN = 1'b0;
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        RSTN = 1'b1;
        chk("t6_rvalid_rst", {31'd0, rvalid3}, 32'd0);
        chk("t6_drdata_rst", drdata3, 32'd0);
        chk("t6_drdata1_rst", drdata1, 32'd0);
        chk("t6_err_rst", {31'd0, err3}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 30'd0, 32'd0);
            chk("t6_no_rvalid", {31'd0, rvalid3}, 32'd0);
            chk("t6_drdata_zero", drdata3, 32'd0);
        end
        drive(1'b1, 1'b0, 30'd1, 32'd0);
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        chk("t6_reread_rvalid", {31'd0, rvalid3}, 32'd1);
        chk("t6_reread_data", drdata3, 32'h55);
        drive(1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b0, 1'b0, 30'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
